// File: rtl/pair_match_ctrl_if.sv
// Button/board bundle between the input conditioning, the round
// controller and the display/scoring logic.
interface pair_match_ctrl_if;
    logic        start;
    logic [39:0] board_in;
    logic [3:0]  target;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_ok;
    logic [39:0] status;
    logic [3:0]  cursor;
    logic [3:0]  first_idx;
    logic        first_valid;
    logic [3:0]  sum;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic [2:0]  state;
    logic        done;
    logic        win;

    modport master (
        output start, board_in, target,
        output btn_up, btn_down, btn_left, btn_right, btn_ok,
        input  status, cursor, first_idx, first_valid,
        input  sum, score, lives, state, done, win
    );

    modport slave (
        input  start, board_in, target,
        input  btn_up, btn_down, btn_left, btn_right, btn_ok,
        output status, cursor, first_idx, first_valid,
        output sum, score, lives, state, done, win
    );
endinterface

// File: rtl/pair_match_ctrl.sv
// Round controller for the two-row tile-pairing game.
// Define PICK_TIMEOUT_EN to add the per-pick timeout counter.
module pair_match_ctrl #(
    parameter int NUM_COLS     = 5,
    parameter int LIVES        = 3,
    parameter int PICK_TIMEOUT = 1000000
) (
    input logic              clk,
    input logic              rst_n,
    pair_match_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PICK1 = 3'd1,
        PICK2 = 3'd2,
        EVAL  = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } state_t;

    localparam logic [3:0] EMPTY = 4'hF;
    localparam logic [3:0] LAST0 = 4'(NUM_COLS - 1);
    localparam logic [3:0] LAST1 = 4'(NUM_COLS + 4);

    if (NUM_COLS < 1 || NUM_COLS > 5 || LIVES < 1 || LIVES > 3 || PICK_TIMEOUT < 1) begin : g_param_check
        $error("pair_match_ctrl: parameter out of range");
    end

    state_t          state_q, state_nx;
    logic [9:0][3:0] board_q, board_nx;
    logic [3:0]      cursor_q, cursor_nx;
    logic [3:0]      first_q, first_nx;
    logic [3:0]      second_q, second_nx;
    logic [3:0]      sum_q, sum_nx;
    logic [3:0]      tgt_q, tgt_nx;
    logic            fv_q, fv_nx;
    logic [7:0]      score_q, score_nx;
    logic [1:0]      lives_q, lives_nx;
    logic [3:0]      cur_tile;
    logic [4:0]      pair_raw;
    logic            expire;

    function automatic logic [3:0] step_right(input logic [3:0] c);
        if (c == LAST0)      return 4'd5;
        else if (c == LAST1) return 4'd0;
        else                 return c + 4'd1;
    endfunction

    function automatic logic [3:0] step_left(input logic [3:0] c);
        if (c == 4'd0)      return LAST1;
        else if (c == 4'd5) return LAST0;
        else                return c - 4'd1;
    endfunction

    function automatic logic [3:0] flip_row(input logic [3:0] c);
        return (c < 4'd5) ? c + 4'd5 : c - 4'd5;
    endfunction

`ifdef PICK_TIMEOUT_EN
    localparam int TW = $clog2(PICK_TIMEOUT + 1);
    logic [TW-1:0] tmr_q;
    logic          in_pick;

    assign in_pick = (state_q == PICK1) || (state_q == PICK2);
    assign expire  = in_pick && (tmr_q == TW'(PICK_TIMEOUT - 1));

    // Any state change (including accepted ok) restarts the pick window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmr_q <= '0;
        else if (bus.start || state_nx != state_q || expire)
            tmr_q <= '0;
        else if (in_pick)
            tmr_q <= tmr_q + 1'b1;
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            board_q  <= {10{EMPTY}};
            cursor_q <= '0;
            first_q  <= '0;
            second_q <= '0;
            sum_q    <= '0;
            tgt_q    <= '0;
            fv_q     <= 1'b0;
            score_q  <= '0;
            lives_q  <= '0;
        end else begin
            state_q  <= state_nx;
            board_q  <= board_nx;
            cursor_q <= cursor_nx;
            first_q  <= first_nx;
            second_q <= second_nx;
            sum_q    <= sum_nx;
            tgt_q    <= tgt_nx;
            fv_q     <= fv_nx;
            score_q  <= score_nx;
            lives_q  <= lives_nx;
        end
    end

    always_comb begin
        state_nx  = state_q;
        board_nx  = board_q;
        cursor_nx = cursor_q;
        first_nx  = first_q;
        second_nx = second_q;
        sum_nx    = sum_q;
        tgt_nx    = tgt_q;
        fv_nx     = fv_q;
        score_nx  = score_q;
        lives_nx  = lives_q;
        cur_tile  = board_q[cursor_q];
        pair_raw  = {1'b0, board_q[first_q]} + {1'b0, cur_tile};

        if (bus.start) begin
            for (int k = 0; k < 10; k++) begin
                if ((k % 5) >= NUM_COLS || bus.board_in[4*k +: 4] > 4'd9)
                    board_nx[k] = EMPTY;
                else
                    board_nx[k] = bus.board_in[4*k +: 4];
            end
            lives_nx  = 2'(LIVES);
            score_nx  = '0;
            cursor_nx = '0;
            fv_nx     = 1'b0;
            tgt_nx    = bus.target;
            state_nx  = PICK1;
        end else begin
            case (state_q)
                PICK1, PICK2: begin
                    if (bus.btn_ok) begin
                        if (state_q == PICK1) begin
                            if (cur_tile != EMPTY) begin
                                first_nx = cursor_q;
                                fv_nx    = 1'b1;
                                state_nx = PICK2;
                            end
                        end else if (cursor_q == first_q) begin
                            fv_nx    = 1'b0;
                            state_nx = PICK1;
                        end else if (cur_tile != EMPTY) begin
                            second_nx = cursor_q;
                            sum_nx    = (pair_raw >= 5'd10) ? 4'(pair_raw - 5'd10)
                                                            : pair_raw[3:0];
                            state_nx  = EVAL;
                        end
                    end else begin
                        priority case (1'b1)
                            bus.btn_up:    cursor_nx = flip_row(cursor_q);
                            bus.btn_down:  cursor_nx = flip_row(cursor_q);
                            bus.btn_left:  cursor_nx = step_left(cursor_q);
                            bus.btn_right: cursor_nx = step_right(cursor_q);
                            default: ;
                        endcase
                    end
                    if (expire && state_q == PICK2 && state_nx == PICK2) begin
                        lives_nx = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                        fv_nx    = 1'b0;
                        state_nx = (lives_nx == 2'd0) ? LOSE : PICK1;
                    end
                end
                EVAL: begin
                    if (sum_q == tgt_q) begin
                        board_nx[first_q]  = EMPTY;
                        board_nx[second_q] = EMPTY;
                        if (score_q != 8'hFF)
                            score_nx = score_q + 8'd1;
                    end else if (lives_q != 2'd0) begin
                        lives_nx = lives_q - 2'd1;
                    end
                    fv_nx = 1'b0;
                    // Empty tiles are all-ones, so a full AND means a cleared board.
                    if (&board_nx)
                        state_nx = WIN;
                    else if (lives_nx == 2'd0)
                        state_nx = LOSE;
                    else
                        state_nx = PICK1;
                end
                default: ;
            endcase
        end
    end

    assign bus.status      = board_q;
    assign bus.cursor      = cursor_q;
    assign bus.first_idx   = first_q;
    assign bus.first_valid = fv_q;
    assign bus.sum         = sum_q;
    assign bus.score       = score_q;
    assign bus.lives       = lives_q;
    assign bus.state       = state_q;
    assign bus.done        = (state_q == WIN) || (state_q == LOSE);
    assign bus.win         = (state_q == WIN);
endmodule

// File: doc/pair_match_ctrl.md
Name: pair_match_ctrl

Overview:
- Round controller for the two-row tile-pairing game.
- Owns the 10-tile board, the cursor and the two-pick sequence.
- Forms (a+b) mod 10 for each picked pair and compares it with the round target. Clears matched tiles, keeps score and lives, and declares win or lose.
- Sits between the debounced button pulses and the display/scoring logic.

Parameters:
NUM_COLS, 5, active columns per row (1..5); row0 tiles 0..NUM_COLS-1, row1 tiles 5..4+NUM_COLS
LIVES, 3, lives loaded on start (1..3)
PICK_TIMEOUT, 1000000, cycles allowed per pick (only with PICK_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  pulse; load board_in/lives, enter PICK1 (any state)
board_in  in  40  tile k at [4k+:4]; k=0..4 row0, 5..9 row1
target  in  4  pair sum target, 0..9, sampled on start
btn_up, btn_down, btn_left, btn_right, btn_ok  in  1 each  single-cycle pulses
status  out  40  current board; 4'hF = empty tile
cursor  out  4  tile index under cursor
first_idx  out  4  index of first pick
first_valid  out  1  first pick held
sum  out  4  last evaluated (a+b) mod 10
score  out  8  matched pairs, saturates at 255
lives  out  2  remaining lives
state  out  3  IDLE=0, PICK1=1, PICK2=2, EVAL=3, WIN=4, LOSE=5
done  out  1  high in WIN/LOSE
win  out  1  high in WIN

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; status all F; cursor 0; first_idx 0; first_valid 0.
  - sum 0; score 0; lives 0; done 0; win 0.
- start, any state:
  - status<=board_in, with nibbles A..E and inactive-column tiles stored as F.
  - lives<=LIVES; score<=0; cursor<=0; first_valid<=0; target latched; state<=PICK1.
- Cursor moves only in PICK1/PICK2. One action per cycle, priority ok > up > down > left > right.
- Up/down toggle row: c<5 -> c+5, else c-5.
- Right walks 0..NUM_COLS-1, then 5..4+NUM_COLS, then wraps to 0. Left is the exact reverse, so left at 0 -> 4+NUM_COLS.
- PICK1, ok:
  - Cursor tile F: ignored.
  - Otherwise first_idx<=cursor, first_valid<=1, state<=PICK2.
- PICK2, ok:
  - Cursor == first_idx: deselect (first_valid<=0, state<=PICK1).
  - Cursor tile F: ignored.
  - Otherwise latch second index, state<=EVAL next cycle.
- EVAL (exactly one cycle):
  - sum = a+b, minus 10 if a+b>=10; registered and visible during EVAL.
  - Match (sum==target): both tiles<=F, score+1 (saturating).
  - Mismatch: lives-1; tiles unchanged.
  - Updates land on the EVAL->next edge. Latency: ok in PICK2 at edge n -> EVAL at n+1 -> updates and next state at n+2.
- After EVAL:
  - All active tiles F -> WIN.
  - Else lives==0 -> LOSE.
  - Else PICK1 with first_valid=0; cursor unchanged.
- WIN/LOSE: done=1 (win=1 in WIN only). All buttons ignored; only start or reset exits.
- IDLE: all buttons ignored.
- Reset asserted mid-operation (including EVAL): outputs return to reset values immediately; no partial update survives.

Optional Feature:
PICK_TIMEOUT_EN:
- Defined:
  - A cycle counter runs in PICK1/PICK2; it reloads on entry to either state and on any accepted ok.
  - Reaching PICK_TIMEOUT in PICK2: lives-1, first_valid<=0, state<=PICK1, or LOSE if lives become 0.
  - Reaching it in PICK1: counter reloads only.
- Undefined: no counter logic; PICK_TIMEOUT unused.

Test Plan:
- Cursor walk (board 1,2,3,4,5,6,7,8,9,0, target 5, NUM_COLS 5; start):
  - right x4 -> cursor 4; right -> 5; left -> 4.
  - up -> 9; left at 0 -> 9.
  - right+ok same cycle -> only ok acts.
- Match: ok tile0 (1), move to tile3 (4), ok -> EVAL sum=5; next cycle tiles 0,3=F, score=1, lives=3, state PICK1.
- Mismatch and pick handling:
  - Tile1 (2) + tile4 (5) -> sum=7, lives 3->2, status unchanged.
  - ok on an F tile ignored.
  - ok twice on the same tile -> first_valid 0.
- Lose: three mismatches -> lives 0, state LOSE, done=1, win=0; subsequent ok/arrows leave all outputs unchanged.
- Win: pairs (0,3) (1,2) (4,9) (5,8) (6,7) -> score 5, status all F, state WIN, done=1, win=1. Then start -> PICK1 with board reloaded.
- Reset: rst_n low during EVAL -> state 0, status all F, score 0 before the next clk edge. With PICK_TIMEOUT_EN and PICK_TIMEOUT=16, idling 16 cycles in PICK2 -> lives-1, state PICK1.
